// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// field widths, the control-output bundle and the load-use compare.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int STALL_CNT_W = 16;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_LU       = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT = 2'b10;
  localparam logic [1:0] ST_FLUSH    = 2'b11;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic bubble_idex;
    logic flush_ifid;
    logic flush_idex;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE = '0;

  // A decode operand only counts when the instruction actually reads it.
  function automatic logic load_use_hit(
    input logic                  ex_mem_read,
    input logic [REG_ADDR_W-1:0] ex_wr_add,
    input logic [REG_ADDR_W-1:0] id_src,
    input logic                  id_use_src,
    input logic [REG_ADDR_W-1:0] id_dst,
    input logic                  id_use_dst
  );
    logic src_match;
    logic dst_match;
    src_match = id_use_src && (id_src == ex_wr_add);
    dst_match = id_use_dst && (id_dst == ex_wr_add);
    return ex_mem_read && (src_match || dst_match);
  endfunction

endpackage

// File: rtl/hazard_ctrl_stall_counter.sv
// Saturating up-counter of stalled cycles; sticks at all-ones instead of
// wrapping so a long-running count never reads back as small.
module stall_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush and load-use bubble
// arbitration, plus a saturating count of PC-stall cycles.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal issue; load-use check active
//   LU       | one-cycle bubble inserted into EX; load-use check suppressed
//   MEM_WAIT | memory stage was busy last cycle; branches are parked
//   FLUSH    | younger stages just cleared; EX holds a bubble
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src,
  input  logic [REG_ADDR_W-1:0]  id_dst,
  input  logic                   id_use_src,
  input  logic                   id_use_dst,
  input  logic                   ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  ex_wr_add,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  output logic                   stall_pc,
  output logic                   stall_ifid,
  output logic                   stall_idex,
  output logic                   stall_exmem,
  output logic                   bubble_idex,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [1:0]             r_state;
  logic                   r_pending_flush;
  logic [1:0]             w_next_state;
  logic                   w_next_pending;
  logic                   w_hit;
  logic                   w_flush_req;
  hz_ctrl_t               w_ctrl;
  logic [STALL_CNT_W-1:0] w_count;

  assign w_hit = load_use_hit(ex_mem_read, ex_wr_add, id_src, id_use_src,
                              id_dst, id_use_dst);

  // FLUSH follows a flush, so no new branch can resolve in EX there.
  assign w_flush_req = (branch_taken || r_pending_flush) && (r_state != ST_FLUSH);

  always_comb begin
    w_ctrl         = CTRL_NONE;
    w_next_state   = ST_RUN;
    w_next_pending = r_pending_flush;
    if (rst) begin
      w_ctrl         = CTRL_NONE;
      w_next_state   = ST_RUN;
      w_next_pending = 1'b0;
    end else if (mem_busy) begin
      w_ctrl.stall_pc    = 1'b1;
      w_ctrl.stall_ifid  = 1'b1;
      w_ctrl.stall_idex  = 1'b1;
      w_ctrl.stall_exmem = 1'b1;
      w_next_state       = ST_MEM_WAIT;
      if ((r_state == ST_MEM_WAIT) && branch_taken) begin
        w_next_pending = 1'b1;
      end
    end else if (w_flush_req) begin
      w_ctrl.flush_ifid = 1'b1;
      w_ctrl.flush_idex = 1'b1;
      w_next_pending    = 1'b0;
      w_next_state      = ST_FLUSH;
    end else if ((r_state == ST_RUN) && w_hit) begin
      w_ctrl.stall_pc    = 1'b1;
      w_ctrl.stall_ifid  = 1'b1;
      w_ctrl.bubble_idex = 1'b1;
      w_next_state       = ST_LU;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_pending_flush <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_pending_flush <= w_next_pending;
    end
  end

  stall_counter #(
    .W (STALL_CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_ctrl.stall_pc),
    .count (w_count)
  );

  assign stall_pc    = w_ctrl.stall_pc;
  assign stall_ifid  = w_ctrl.stall_ifid;
  assign stall_idex  = w_ctrl.stall_idex;
  assign stall_exmem = w_ctrl.stall_exmem;
  assign bubble_idex = w_ctrl.bubble_idex;
  assign flush_ifid  = w_ctrl.flush_ifid;
  assign flush_idex  = w_ctrl.flush_idex;
  assign stall_cnt   = rst ? '0 : w_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected outputs are queued as each cycle
// is driven and popped when the combinational outputs have settled.
module tb_hazard_ctrl;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_MEM  = 7'b1111000;
  localparam logic [6:0] O_FL   = 7'b0000011;

  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_LU  = 2'b01;
  localparam logic [1:0] S_MW  = 2'b10;
  localparam logic [1:0] S_FL  = 2'b11;

  logic        clk;
  logic        rst;
  logic [2:0]  id_src;
  logic [2:0]  id_dst;
  logic        id_use_src;
  logic        id_use_dst;
  logic        ex_mem_read;
  logic [2:0]  ex_wr_add;
  logic        branch_taken;
  logic        mem_busy;
  logic        stall_pc;
  logic        stall_ifid;
  logic        stall_idex;
  logic        stall_exmem;
  logic        bubble_idex;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] stall_cnt;

  typedef struct {
    string      nm;
    logic [6:0] outs;
    logic [15:0] cnt;
    logic       chk_st;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_src       (id_src),
    .id_dst       (id_dst),
    .id_use_src   (id_use_src),
    .id_use_dst   (id_use_dst),
    .ex_mem_read  (ex_mem_read),
    .ex_wr_add    (ex_wr_add),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .stall_idex   (stall_idex),
    .stall_exmem  (stall_exmem),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input logic r, input logic mr, input logic [2:0] wr,
                     input logic [2:0] src, input logic us,
                     input logic [2:0] dst, input logic ud,
                     input logic bt, input logic mb);
    rst          = r;
    ex_mem_read  = mr;
    ex_wr_add    = wr;
    id_src       = src;
    id_use_src   = us;
    id_dst       = dst;
    id_use_dst   = ud;
    branch_taken = bt;
    mem_busy     = mb;
  endtask

  // One cycle: drive after the falling edge, queue the expectation, compare
  // once the combinational outputs settle, before the next rising edge.
  task automatic step(input string nm, input logic r, input logic mr,
                      input logic [2:0] wr, input logic [2:0] src,
                      input logic us, input logic [2:0] dst, input logic ud,
                      input logic bt, input logic mb, input logic [6:0] eo,
                      input logic [15:0] ec, input logic cs,
                      input logic [1:0] es);
    exp_t e;
    exp_t got;
    logic [6:0] outs;
    @(negedge clk);
    drv(r, mr, wr, src, us, dst, ud, bt, mb);
    e.nm = nm; e.outs = eo; e.cnt = ec; e.chk_st = cs; e.st = es;
    sb.push_back(e);
    #2;
    got  = sb.pop_front();
    outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_idex,
            flush_ifid, flush_idex};
    total++;
    if (outs !== got.outs) begin
      bad++;
      $display("FAIL %s outs actual=%b required=%b", got.nm, outs, got.outs);
    end
    total++;
    if (stall_cnt !== got.cnt) begin
      bad++;
      $display("FAIL %s stall_cnt actual=%0d required=%0d", got.nm, stall_cnt, got.cnt);
    end
    if (got.chk_st) begin
      total++;
      if (dut.r_state !== got.st) begin
        bad++;
        $display("FAIL %s state actual=%b required=%b", got.nm, dut.r_state, got.st);
      end
    end
  endtask

  task automatic test_reset();
    step("rst_first", 1, 1, 3'd3, 3'd3, 1, 3'd3, 1, 1, 1, O_NONE, 16'd0, 0, S_RUN);
    step("rst_hold",  1, 1, 3'd3, 3'd3, 1, 3'd3, 1, 1, 0, O_NONE, 16'd0, 1, S_RUN);
  endtask

  task automatic test_load_use();
    step("lu_idle",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd0, 1, S_RUN);
    step("lu_hit",    0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 0, 0, O_LU,   16'd0, 1, S_RUN);
    step("lu_supp",   0, 1, 3'd3, 3'd3, 1, 3'd0, 0, 0, 0, O_NONE, 16'd1, 1, S_LU);
    step("lu_back",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd1, 1, S_RUN);
  endtask

  task automatic test_no_false_hit();
    step("nf_dst5",   0, 1, 3'd3, 3'd3, 0, 3'd5, 1, 0, 0, O_NONE, 16'd1, 1, S_RUN);
    step("nf_nold",   0, 0, 3'd3, 3'd3, 1, 3'd3, 1, 0, 0, O_NONE, 16'd1, 1, S_RUN);
    step("nf_dst3",   0, 1, 3'd3, 3'd3, 0, 3'd3, 1, 0, 0, O_LU,   16'd1, 1, S_RUN);
    step("nf_lu",     0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd2, 1, S_LU);
    step("nf_run",    0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd2, 1, S_RUN);
  endtask

  task automatic test_mem_freeze();
    step("mf_c1",     0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'd2, 1, S_RUN);
    step("mf_c2_br",  0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, O_MEM,  16'd3, 1, S_MW);
    step("mf_c3",     0, 1, 3'd2, 3'd2, 1, 3'd0, 0, 0, 1, O_MEM,  16'd4, 1, S_MW);
    step("mf_c4",     0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'd5, 1, S_MW);
    step("mf_flush",  0, 1, 3'd2, 3'd2, 1, 3'd0, 0, 0, 0, O_FL,   16'd6, 1, S_MW);
    step("mf_flst",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd6, 1, S_FL);
    step("mf_run",    0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd6, 1, S_RUN);
    // MEM_WAIT released with no flush parked: quiet even with a live hit.
    step("mw_busy",   0, 1, 3'd4, 3'd4, 1, 3'd0, 0, 0, 1, O_MEM,  16'd6, 1, S_RUN);
    step("mw_quiet",  0, 1, 3'd4, 3'd4, 1, 3'd0, 0, 0, 0, O_NONE, 16'd7, 1, S_MW);
    step("mw_run",    0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd7, 1, S_RUN);
  endtask

  task automatic test_priority();
    step("pr_br_hit", 0, 1, 3'd1, 3'd1, 1, 3'd0, 0, 1, 0, O_FL,   16'd7, 1, S_RUN);
    step("pr_fl_hit", 0, 1, 3'd1, 3'd1, 1, 3'd0, 0, 0, 0, O_NONE, 16'd7, 1, S_FL);
    step("pr_run",    0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd7, 1, S_RUN);
    step("pr_mb_hit", 0, 1, 3'd6, 3'd0, 0, 3'd6, 1, 0, 1, O_MEM,  16'd7, 1, S_RUN);
    step("pr_mw",     0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd8, 1, S_MW);
    step("pr_lu_br",  0, 1, 3'd6, 3'd6, 1, 3'd0, 0, 1, 0, O_FL,   16'd8, 1, S_RUN);
    step("pr_done",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd8, 1, S_FL);
  endtask

  task automatic test_reset_mid();
    step("rm_busy",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'd8, 1, S_RUN);
    step("rm_park",   0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 1, O_MEM,  16'd9, 1, S_MW);
    step("rm_rst",    1, 1, 3'd2, 3'd2, 1, 3'd0, 0, 1, 1, O_NONE, 16'd0, 1, S_MW);
    step("rm_rel",    0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd0, 1, S_RUN);
    step("rm_quiet",  0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'd0, 1, S_RUN);
  endtask

  task automatic test_saturation();
    step("sat_start", 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'd0, 1, S_RUN);
    repeat (65535) @(posedge clk);
    step("sat_ffff",  0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'hFFFF, 1, S_MW);
    step("sat_hold1", 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, O_MEM,  16'hFFFF, 1, S_MW);
    step("sat_hold2", 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, O_NONE, 16'hFFFF, 1, S_MW);
  endtask

  initial begin
    drv(1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_no_false_hit();
    test_mem_freeze();
    test_priority();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_src  in  3  decode-stage source register address
- id_dst  in  3  decode-stage destination-as-source register address
- id_use_src  in  1  decode instruction reads id_src
- id_use_dst  in  1  decode instruction reads id_dst
- ex_mem_read  in  1  instruction in EX is a load
- ex_wr_add  in  3  EX-stage write address
- branch_taken  in  1  EX resolved a taken branch or jump
- mem_busy  in  1  memory stage needs another cycle
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID register
- stall_idex  out  1  hold ID/EX register
- stall_exmem  out  1  hold EX/MEM register
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- flush_idex  out  1  clear ID/EX
- stall_cnt  out  16  saturating count of stall_pc cycles

Function
REQ-003 The FSM SHALL have four states: RUN, LU (load-use bubble), MEM_WAIT, FLUSH; all outputs other than stall_cnt SHALL be combinational in state and current inputs.
REQ-004 Load-use hit SHALL be: ex_mem_read=1 and ((id_use_src=1 and id_src==ex_wr_add) or (id_use_dst=1 and id_dst==ex_wr_add)).
REQ-005 Per-cycle priority SHALL be: mem_busy > branch_taken (or pending flush) > load-use hit.
REQ-006 In any state, mem_busy=1 SHALL assert stall_pc, stall_ifid, stall_idex and stall_exmem, deassert all flush/bubble outputs, and select next state MEM_WAIT.
REQ-007 In MEM_WAIT with mem_busy=1, branch_taken=1 SHALL set the internal pending_flush register; pending_flush SHALL hold until it is consumed.
REQ-008 In RUN, LU or MEM_WAIT with mem_busy=0, if branch_taken=1 or pending_flush=1, the block SHALL assert flush_ifid and flush_idex for that cycle, clear pending_flush, and go to FLUSH.
REQ-009 In RUN with no higher-priority event, a load-use hit SHALL assert stall_pc, stall_ifid and bubble_idex for exactly one cycle and go to LU.
REQ-010 In LU and FLUSH, the load-use check SHALL be suppressed, because EX then holds a bubble; the next state SHALL be RUN unless REQ-006 or REQ-008 applies.
REQ-011 In MEM_WAIT with mem_busy=0 and no flush, all outputs SHALL be 0 and the next state SHALL be RUN.
REQ-012 stall_cnt SHALL increment by 1 on each clk edge where stall_pc=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-013 A stall and a flush SHALL never be asserted in the same cycle; bubble_idex and flush_idex SHALL be mutually exclusive.

Reset
REQ-014 While rst=1, all outputs SHALL be 0 regardless of inputs.
REQ-015 On the first edge with rst=1: state SHALL become RUN, pending_flush 0, stall_cnt 0.
REQ-016 Reset SHALL take effect from any state, including mid-MEM_WAIT with pending_flush=1; that pending flush SHALL be discarded.

Structure
REQ-017 A shared package SHALL hold the state encoding (RUN=2'b00, LU=2'b01, MEM_WAIT=2'b10, FLUSH=2'b11), REG_ADDR_W=3 and STALL_CNT_W=16.
REQ-018 The saturating counter SHALL be a sub-module named stall_counter (ports clk, rst, inc, count).

Verification
REQ-019 Load-use: ex_mem_read=1, ex_wr_add=3, id_src=3, id_use_src=1 -> stall_pc=stall_ifid=bubble_idex=1 for 1 cycle, state LU, then RUN; stall_cnt=1.
REQ-020 No false hit: same as REQ-019 but id_use_src=0, id_use_dst=1, id_dst=5 -> no stall; the hit with id_dst=3 stalls.
REQ-021 Memory freeze: mem_busy=1 for 4 cycles, branch_taken=1 in the 2nd -> all four stall_* high for 4 cycles, then flush_ifid=flush_idex=1 on the 5th cycle, state FLUSH; stall_cnt=4.
REQ-022 Priority: branch_taken=1 with a simultaneous load-use hit in RUN -> flushes only, no bubble, state FLUSH.
REQ-023 Reset mid-operation: rst=1 in MEM_WAIT with pending_flush=1 -> outputs 0, after release no flush, state RUN, stall_cnt=0.
REQ-024 Saturation: preload the count via 65535 forced stall cycles, then 2 more -> stall_cnt holds 16'hFFFF.
